// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: byte strobe inputs, consumer controls and status outputs of the receive FIFO.
interface uart_rx_fifo_if #(
   parameter int DEPTH = 16
) ();
   localparam int LW = $clog2(DEPTH) + 1;
   logic          received;
   logic [7:0]    rx_byte;
   logic          recv_error;
   logic          pop;
   logic          flush;
   logic          clr_overrun;
   logic [LW-1:0] thresh;
   logic [7:0]    rd_data;
   logic          rd_err;
   logic          rd_valid;
   logic [LW-1:0] level;
   logic          overrun;
   logic          irq;
   modport master (
      output received, rx_byte, recv_error, pop, flush, clr_overrun, thresh,
      input  rd_data, rd_err, rd_valid, level, overrun, irq
   );
   modport slave (
      input  received, rx_byte, recv_error, pop, flush, clr_overrun, thresh,
      output rd_data, rd_err, rd_valid, level, overrun, irq
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive byte FIFO with first-word-fall-through read, level count, sticky overrun and threshold irq.
// Defining UART_RX_FIFO_ERR_TAG_EN stores recv_error alongside each byte and exposes it on rd_err.
module uart_rx_fifo #(
   parameter int DEPTH = 16
) (
   input logic clk,
   input logic rst,
   uart_rx_fifo_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
`ifdef UART_RX_FIFO_ERR_TAG_EN
   localparam int W = 9;
`else
   localparam int W = 8;
`endif
   logic [W-1:0]  mem [DEPTH];
   logic [W-1:0]  wr_word;
   logic [W-1:0]  head;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] cnt, cnt_next;
   logic          pop_ok, push_ok, push, drop, valid, ov_q, irq_q;
`ifdef UART_RX_FIFO_ERR_TAG_EN
   assign wr_word = {bus.recv_error, bus.rx_byte};
   assign bus.rd_err = valid && head[8];
`else
   logic unused_err;
   assign unused_err = bus.recv_error;
   assign wr_word = bus.rx_byte;
   assign bus.rd_err = 1'b0;
`endif
   // accept/drop decisions; flush discards any same-cycle byte and empties the buffer
   always_comb begin
      pop_ok = bus.pop && cnt != '0;
      push_ok = bus.received && (cnt != LW'(DEPTH) || pop_ok);
      push = push_ok && !bus.flush;
      drop = bus.received && !push_ok && !bus.flush;
      cnt_next = bus.flush ? '0 : cnt + LW'(push) - LW'(pop_ok);
   end
   // pointers, level counter, sticky overrun (set beats clear) and registered irq on post-update level
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt <= '0;
         ov_q <= 1'b0;
         irq_q <= 1'b0;
      end else begin
         wr_ptr <= bus.flush ? '0 : wr_ptr + PW'(push);
         rd_ptr <= bus.flush ? '0 : rd_ptr + PW'(pop_ok);
         cnt <= cnt_next;
         ov_q <= drop ? 1'b1 : bus.clr_overrun ? 1'b0 : ov_q;
         irq_q <= bus.thresh != '0 && cnt_next >= bus.thresh;
      end
   end
   // storage array, contents are don't-care until written
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_word;
   end
   assign head = mem[rd_ptr];
   assign valid = cnt != '0;
   assign bus.rd_valid = valid;
   assign bus.rd_data = valid ? head[7:0] : 8'h00;
   assign bus.level = cnt;
   assign bus.overrun = ov_q;
   assign bus.irq = irq_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: table vectors, directed corner sequences and random traffic against a queue-based model.
module tb_uart_rx_fifo;
   localparam int DEPTH = 16;
   localparam int LW = $clog2(DEPTH) + 1;
`ifdef UART_RX_FIFO_ERR_TAG_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif
   typedef struct {
      int r, rcv, b, e, p, f, c, th;
      int lvl, data, vld, ov, irq;
   } vec_t;
   logic clk = 1'b0;
   logic rst;
   int tests = 0;
   int fails = 0;
   int cur_th = 0;
   logic [8:0] q[$];
   logic m_ov = 1'b0;
   logic m_irq = 1'b0;
   vec_t v[$];
   uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();
   uart_rx_fifo #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic step(input int r, input int rcv, input int b, input int e, input int p,
                       input int f, input int c, input int th);
      logic popped, full, set;
      rst = 1'(r);
      bus.received = 1'(rcv);
      bus.rx_byte = 8'(b);
      bus.recv_error = 1'(e);
      bus.pop = 1'(p);
      bus.flush = 1'(f);
      bus.clr_overrun = 1'(c);
      bus.thresh = LW'(th);
      @(posedge clk);
      set = 1'b0;
      if (r != 0) begin
         q.delete();
         m_ov = 1'b0;
         m_irq = 1'b0;
      end else begin
         if (f != 0) q.delete();
         else begin
            popped = p != 0 && q.size() != 0;
            full = q.size() == DEPTH;
            if (popped) void'(q.pop_front());
            if (rcv != 0 && (!full || popped)) q.push_back({1'(e), 8'(b)});
            else if (rcv != 0) set = 1'b1;
         end
         m_ov = set ? 1'b1 : c != 0 ? 1'b0 : m_ov;
         m_irq = th != 0 && q.size() >= th;
      end
      #1;
      check("model_level", 32'(bus.level), 32'(q.size()));
      check("model_valid", 32'(bus.rd_valid), 32'(q.size() != 0));
      check("model_data", 32'(bus.rd_data), q.size() != 0 ? 32'(q[0][7:0]) : 32'd0);
      check("model_err", 32'(bus.rd_err), (ERR_EN && q.size() != 0) ? 32'(q[0][8]) : 32'd0);
      check("model_overrun", 32'(bus.overrun), 32'(m_ov));
      check("model_irq", 32'(bus.irq), 32'(m_irq));
   endtask
   task automatic add(input int r, input int rcv, input int b, input int e, input int p, input int f,
                      input int c, input int th, input int lvl, input int data, input int vld,
                      input int ov, input int irq);
      vec_t t;
      t = '{r, rcv, b, e, p, f, c, th, lvl, data, vld, ov, irq};
      v.push_back(t);
   endtask
   task automatic push(input int b, input int e);
      step(0, 1, b, e, 0, 0, 0, cur_th);
   endtask
   task automatic pop1();
      step(0, 0, 0, 0, 1, 0, 0, cur_th);
   endtask
   initial begin
      add(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
      add(0, 1, 8'h41, 0, 0, 0, 0, 0, 1, 8'h41, 1, 0, 0);
      add(0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0);
      add(0, 1, 8'h33, 0, 1, 0, 0, 0, 1, 8'h33, 1, 0, 0);
      add(0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0);
      add(0, 1, 8'h01, 0, 0, 0, 0, 4, 1, 8'h01, 1, 0, 0);
      add(0, 1, 8'h02, 0, 0, 0, 0, 4, 2, 8'h01, 1, 0, 0);
      add(0, 1, 8'h03, 0, 0, 0, 0, 4, 3, 8'h01, 1, 0, 0);
      add(0, 1, 8'h04, 0, 0, 0, 0, 4, 4, 8'h01, 1, 0, 1);
      add(0, 0, 8'h00, 0, 1, 0, 0, 4, 3, 8'h02, 1, 0, 0);
      for (int i = 5; i <= 9; i++) add(0, 1, i, 0, 0, 0, 0, 4, i - 1, 8'h02, 1, 0, 1);
      add(0, 0, 8'h00, 0, 0, 0, 0, 0, 8, 8'h02, 1, 0, 0);
      add(0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0);
      foreach (v[i]) begin
         step(v[i].r, v[i].rcv, v[i].b, v[i].e, v[i].p, v[i].f, v[i].c, v[i].th);
         check("tbl_level", 32'(bus.level), 32'(v[i].lvl));
         check("tbl_data", 32'(bus.rd_data), 32'(v[i].data));
         check("tbl_valid", 32'(bus.rd_valid), 32'(v[i].vld));
         check("tbl_overrun", 32'(bus.overrun), 32'(v[i].ov));
         check("tbl_irq", 32'(bus.irq), 32'(v[i].irq));
      end
      for (int i = 0; i < DEPTH; i++) push(i, 0);
      check("fill_level", 32'(bus.level), 32'd16);
      check("fill_overrun", 32'(bus.overrun), 32'd0);
      push(8'hAA, 0);
      check("drop_level", 32'(bus.level), 32'd16);
      check("drop_overrun", 32'(bus.overrun), 32'd1);
      for (int i = 0; i < DEPTH; i++) begin
         check("drain_data", 32'(bus.rd_data), 32'(i));
         pop1();
      end
      check("drain_level", 32'(bus.level), 32'd0);
      check("drain_data_empty", 32'(bus.rd_data), 32'd0);
      push(8'h5A, 0);
      step(0, 1, 8'h99, 0, 0, 1, 0, cur_th);
      check("flush_level", 32'(bus.level), 32'd0);
      check("flush_overrun_kept", 32'(bus.overrun), 32'd1);
      step(0, 0, 0, 0, 0, 0, 1, cur_th);
      check("clr_overrun", 32'(bus.overrun), 32'd0);
      for (int i = 0; i < DEPTH; i++) push(8'h20 + i, 0);
      step(0, 1, 8'h55, 0, 1, 0, 0, cur_th);
      check("full_pushpop_level", 32'(bus.level), 32'd16);
      check("full_pushpop_overrun", 32'(bus.overrun), 32'd0);
      for (int i = 1; i <= DEPTH; i++) begin
         check("wrap_data", 32'(bus.rd_data), i < DEPTH ? 32'(8'h20 + i) : 32'h55);
         pop1();
      end
      cur_th = 16;
      for (int i = 0; i < DEPTH; i++) push(i, 0);
      check("irq_at_full", 32'(bus.irq), 32'd1);
      cur_th = 17;
      step(0, 0, 0, 0, 0, 0, 0, cur_th);
      check("irq_thresh_above_depth", 32'(bus.irq), 32'd0);
      cur_th = 0;
      step(0, 1, 8'h77, 0, 0, 0, 1, cur_th);
      check("set_beats_clear", 32'(bus.overrun), 32'd1);
      step(0, 0, 0, 0, 0, 1, 1, cur_th);
      push(8'h10, 1);
      push(8'h11, 0);
      check("err_tag_first", 32'(bus.rd_err), 32'(ERR_EN));
      pop1();
      check("err_tag_second_data", 32'(bus.rd_data), 32'h11);
      check("err_tag_second", 32'(bus.rd_err), 32'd0);
      pop1();
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 99) < 5) cur_th = $urandom_range(0, 20);
         step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 55, $urandom_range(0, 255),
              $urandom_range(0, 1), $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 2,
              $urandom_range(0, 99) < 5, cur_th);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer between the UART core's byte strobe (`received`/`rx_byte`/`recv_error`) and the PCPI UART front-end.
- Decouples byte arrival from software reads so back-to-back bytes are not lost while the core stalls on a URX instruction.
- Provides first-word-fall-through read data, fill level, sticky overrun flag and a threshold-based level interrupt.
- Sits directly downstream of the UART core and upstream of the PCPI instruction logic.

Parameters:
- DEPTH, 16, number of byte entries; power of two, >= 2.
- LW, $clog2(DEPTH)+1, width of level/threshold fields (derived, not overridden).

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- received  input  1  single-cycle strobe from UART core: rx_byte valid.
- rx_byte  input  8  received byte.
- recv_error  input  1  framing error flag for the current byte, qualified by received.
- pop  input  1  consumer acknowledges head entry this cycle.
- flush  input  1  discard all entries.
- clr_overrun  input  1  clear sticky overrun flag.
- thresh  input  LW  interrupt threshold; 0 disables irq.
- rd_data  output  8  head entry byte; 0 when empty.
- rd_err  output  1  head entry error tag (see Optional Feature).
- rd_valid  output  1  FIFO non-empty.
- level  output  LW  number of stored entries, 0..DEPTH.
- overrun  output  1  sticky: a byte was dropped because the FIFO was full.
- irq  output  1  registered level interrupt.

Behaviour:
- Reset (rst=1 at posedge):
  - wr_ptr=rd_ptr=0, level=0, overrun=0, irq=0.
  - Storage contents don't-care; rd_data/rd_err forced 0 when empty.
- Storage and read path:
  - Circular buffer, pointers log2(DEPTH) bits, natural wrap from DEPTH-1 to 0.
  - level is a separate LW-bit counter, not derived from pointers, so full vs empty is unambiguous.
  - rd_data/rd_err/rd_valid are combinational from storage[rd_ptr] and level; FWFT, zero read latency.
- Push and pop rules:
  - push_ok = received && (level<DEPTH || pop_ok).
  - pop_ok = pop && level!=0.
  - pop when empty: ignored, no state change.
  - Full and received without pop: byte dropped, overrun<=1, pointers unchanged.
  - Full and received with pop: both happen, level stays DEPTH, no overrun.
  - Empty and received with pop: push only, pop ignored, level becomes 1.
  - Push written byte becomes visible on rd_data the cycle after the strobe (level 0→1).
- Priority per cycle: rst > flush > push/pop.
  - flush: pointers and level to 0, and any same-cycle received byte is discarded.
  - Flush does not clear overrun.
- overrun: set has priority over clr_overrun in the same cycle; otherwise clr_overrun clears it.
- irq <= (thresh!=0) && (level_next >= thresh).
  - level_next is the post-update level, so irq asserts in the same cycle level changes.
  - thresh > DEPTH: irq never asserts.
  - No internal acknowledge: irq deasserts when pops bring level below thresh, or when thresh is changed.
- No combinational path from received/rx_byte to any output.

Optional Feature:
- Macro: UART_RX_FIFO_ERR_TAG_EN.
- Defined:
  - Storage is 9 bits per entry; recv_error stored with each byte.
  - rd_err reflects the head entry's tag.
  - A byte with recv_error=1 is still stored.
- Undefined:
  - Storage is 8 bits; recv_error ignored; rd_err tied 0.
  - All other behaviour identical.

Test Plan:
1. rst, then received with rx_byte=0x41 → next cycle rd_valid=1, rd_data=0x41, level=1; pop → rd_valid=0, level=0, rd_data=0.
2. 16 pushes 0x00..0x0F (DEPTH=16), then push 0xAA → level=16, overrun=1, 0xAA dropped; 16 pops return 0x00..0x0F in order, exercising pointer wrap.
3. Full FIFO, received 0x55 with pop in same cycle → level stays 16, overrun=0, 0x55 is the last entry popped.
4. Empty FIFO, received 0x33 with pop in same cycle → level=1, rd_data=0x33; separately, flush with received in the same cycle → level=0, byte lost, overrun unchanged.
5. thresh=4: push 3 bytes → irq=0; 4th push → irq=1; one pop → irq=0; thresh=0 with level=8 → irq=0.
6. With UART_RX_FIFO_ERR_TAG_EN: push 0x10 with recv_error=1, then 0x11 with recv_error=0 → rd_err=1 then 0 across pops. Without the macro, rd_err=0 throughout. In both builds, clr_overrun and an overrun event in the same cycle → overrun=1.
